// File: rtl/mem_stage_pkg.sv
// Shared Y86 definitions for the memory-access stage: icodes, register IDs,
// status codes, request FSM states and the address-range helper.
package mem_stage_pkg;

  localparam int BYTE = 8;
  localparam int WORD = 32;

  localparam logic [BYTE-1:0] IHALT   = 8'h00;
  localparam logic [BYTE-1:0] INOP    = 8'h01;
  localparam logic [BYTE-1:0] IRMMOVL = 8'h04;
  localparam logic [BYTE-1:0] IMRMOVL = 8'h05;
  localparam logic [BYTE-1:0] ICALL   = 8'h08;
  localparam logic [BYTE-1:0] IRET    = 8'h09;
  localparam logic [BYTE-1:0] IPUSHL  = 8'h0A;
  localparam logic [BYTE-1:0] IPOPL   = 8'h0B;

  localparam logic [BYTE-1:0] RNONE   = 8'h0F;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10
  } stat_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RD_WAIT,
    S_FROZEN
  } mstate_e;

  // A 4-byte word at addr must fit entirely below mem_bytes; no wrap on addr+3.
  function automatic logic addr_in_range(input logic [WORD-1:0] addr,
                                         input logic [WORD-1:0] mem_bytes);
    return addr <= (mem_bytes - WORD'(4));
  endfunction

endpackage

// File: rtl/mem_stage_dmem_if.sv
// Data-memory request FSM: presents one request at a time over valid/ready,
// waits for read data, and parks in FROZEN after a fault or halt.
module mem_stage_dmem_if
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_op,
  input  logic            op_we,
  input  logic            op_legal,
  input  logic            op_halt,
  input  logic [WORD-1:0] op_addr,
  input  logic [WORD-1:0] op_wdata,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [WORD-1:0] dmem_addr,
  output logic [WORD-1:0] dmem_wdata,
  output logic            stall,
  output logic            frozen
);

  mstate_e         state;
  logic            lat_we;
  logic [WORD-1:0] lat_addr;
  logic [WORD-1:0] lat_wdata;
  logic            idle;
  logic            in_req;
  logic            in_wait;
  logic            issue;

  assign idle    = (state == S_IDLE);
  assign in_req  = (state == S_REQ);
  assign in_wait = (state == S_RD_WAIT);
  assign frozen  = (state == S_FROZEN);

  // Gated by rst so nothing is requested while reset is held with an op present.
  assign issue = rst & idle & mem_op & op_legal;

  assign dmem_req   = issue | in_req;
  assign dmem_we    = in_req ? lat_we    : (issue & op_we);
  assign dmem_addr  = in_req ? lat_addr  : op_addr;
  assign dmem_wdata = in_req ? lat_wdata : op_wdata;

  assign stall = (issue   & ~(op_we  & dmem_ready)) |
                 (in_req  & ~(lat_we & dmem_ready)) |
                 (in_wait & ~dmem_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_halt || (mem_op && !op_legal)) state <= S_FROZEN;
          else if (mem_op) begin
            if (!dmem_ready) state <= S_REQ;
            else if (!op_we) state <= S_RD_WAIT;
          end
        end
        S_REQ: begin
          if (dmem_ready) state <= lat_we ? S_IDLE : S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (dmem_rvalid) state <= S_IDLE;
        end
        default: state <= S_FROZEN;
      endcase
    end
  end

  // Request fields are captured on first presentation and replayed while in REQ.
  always_ff @(posedge clk) begin
    if (idle) begin
      lat_we    <= op_we;
      lat_addr  <= op_addr;
      lat_wdata <= op_wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Y86 memory-access stage: decodes the EX/MEM icode into a data-memory access,
// stalls upstream while it is outstanding and registers the result to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] DMEM_BYTES = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BYTE-1:0] mem_icode,
  input  logic [WORD-1:0] mem_valA,
  input  logic [WORD-1:0] mem_valP,
  input  logic [WORD-1:0] mem_valE,
  input  logic [BYTE-1:0] mem_dstE,
  input  logic [BYTE-1:0] mem_dstM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [WORD-1:0] dmem_addr,
  output logic [WORD-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [WORD-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [BYTE-1:0] wb_icode,
  output logic [WORD-1:0] wb_valE,
  output logic [WORD-1:0] wb_valM,
  output logic [BYTE-1:0] wb_dstE,
  output logic [BYTE-1:0] wb_dstM,
  output logic [1:0]      wb_stat
);

  logic            is_rd;
  logic            is_wr;
  logic            mem_op;
  logic            legal;
  logic            fault;
  logic            halt;
  logic            frozen;
  logic [WORD-1:0] op_addr;
  logic [WORD-1:0] op_wdata;

  always_comb begin
    is_rd    = 1'b0;
    is_wr    = 1'b0;
    op_addr  = mem_valE;
    op_wdata = mem_valA;
    case (mem_icode)
      IRMMOVL, IPUSHL: is_wr = 1'b1;
      ICALL: begin
        is_wr    = 1'b1;
        op_wdata = mem_valP;
      end
      IMRMOVL: is_rd = 1'b1;
      IPOPL, IRET: begin
        is_rd   = 1'b1;
        op_addr = mem_valA;
      end
      default: ;
    endcase
  end

  assign mem_op = is_rd | is_wr;
  assign legal  = addr_in_range(op_addr, DMEM_BYTES);
  assign fault  = mem_op & ~legal;
  assign halt   = (mem_icode == IHALT);

  mem_stage_dmem_if u_dmem_if (
    .clk         (clk),
    .rst         (rst),
    .mem_op      (mem_op),
    .op_we       (is_wr),
    .op_legal    (legal),
    .op_halt     (halt),
    .op_addr     (op_addr),
    .op_wdata    (op_wdata),
    .dmem_ready  (dmem_ready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .stall       (mem_stall),
    .frozen      (frozen)
  );

  // MEM/WB boundary: bubbles while stalled or frozen, status sticks across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_icode <= INOP;
      wb_valE  <= '0;
      wb_valM  <= '0;
      wb_dstE  <= RNONE;
      wb_dstM  <= RNONE;
      wb_stat  <= STAT_AOK;
    end else if (frozen || mem_stall) begin
      wb_icode <= INOP;
      wb_valE  <= '0;
      wb_valM  <= '0;
      wb_dstE  <= RNONE;
      wb_dstM  <= RNONE;
    end else begin
      wb_icode <= mem_icode;
      wb_valE  <= mem_valE;
      wb_valM  <= (is_rd && legal) ? dmem_rdata : '0;
      wb_dstE  <= fault ? RNONE : mem_dstE;
      wb_dstM  <= fault ? RNONE : mem_dstM;
      wb_stat  <= fault ? STAT_ADR : (halt ? STAT_HLT : STAT_AOK);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-cycle vectors of inputs with hand-computed
// bus outputs and writeback results, plus fault/halt/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_icode;
  logic [31:0] mem_valA, mem_valP, mem_valE;
  logic [7:0]  mem_dstE, mem_dstM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [7:0]  wb_icode;
  logic [31:0] wb_valE, wb_valM;
  logic [7:0]  wb_dstE, wb_dstM;
  logic [1:0]  wb_stat;

  int n_chk = 0;
  int n_err = 0;

  mem_stage #(.DMEM_BYTES(32'h0000_1000)) dut (
    .clk(clk), .rst(rst),
    .mem_icode(mem_icode), .mem_valA(mem_valA), .mem_valP(mem_valP), .mem_valE(mem_valE),
    .mem_dstE(mem_dstE), .mem_dstM(mem_dstM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .wb_icode(wb_icode), .wb_valE(wb_valE), .wb_valM(wb_valM),
    .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_stat(wb_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  icode;
    logic [31:0] valA, valP, valE;
    logic [7:0]  dstE, dstM;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        x_req, x_we;
    logic [31:0] x_addr, x_wdata;
    logic        x_stall;
    logic [7:0]  x_icode;
    logic [31:0] x_valE, x_valM;
    logic [7:0]  x_dstE, x_dstM;
    logic [1:0]  x_stat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [7:0] icode, input logic [31:0] valA, valP, valE,
    input logic [7:0] dstE, dstM, input logic ready, rvalid, input logic [31:0] rdata,
    input logic x_req, x_we, input logic [31:0] x_addr, x_wdata, input logic x_stall,
    input logic [7:0] x_icode, input logic [31:0] x_valE, x_valM,
    input logic [7:0] x_dstE, x_dstM, input logic [1:0] x_stat);
    vec_t v;
    v.icode = icode; v.valA = valA; v.valP = valP; v.valE = valE;
    v.dstE = dstE; v.dstM = dstM; v.ready = ready; v.rvalid = rvalid; v.rdata = rdata;
    v.x_req = x_req; v.x_we = x_we; v.x_addr = x_addr; v.x_wdata = x_wdata;
    v.x_stall = x_stall; v.x_icode = x_icode; v.x_valE = x_valE; v.x_valM = x_valM;
    v.x_dstE = x_dstE; v.x_dstM = x_dstM; v.x_stat = x_stat;
    return v;
  endfunction

  // Row whose writeback result is the bubble (nop, no dst, zero values).
  function automatic vec_t mkb(
    input logic [7:0] icode, input logic [31:0] valA, valP, valE,
    input logic [7:0] dstE, dstM, input logic ready, rvalid, input logic [31:0] rdata,
    input logic x_req, x_we, input logic [31:0] x_addr, x_wdata, input logic x_stall,
    input logic [1:0] x_stat);
    return mk(icode, valA, valP, valE, dstE, dstM, ready, rvalid, rdata,
              x_req, x_we, x_addr, x_wdata, x_stall, 8'h01, 0, 0, 8'h0F, 8'h0F, x_stat);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_nop();
    mem_icode = 8'h01; mem_valA = 0; mem_valP = 0; mem_valE = 0;
    mem_dstE = 8'h0F; mem_dstM = 8'h0F;
    dmem_ready = L; dmem_rvalid = L; dmem_rdata = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},   32'(dmem_req), 0);
    chk({tag, ".stall"}, 32'(mem_stall), 0);
    chk({tag, ".icode"}, 32'(wb_icode), 32'h01);
    chk({tag, ".valE"},  wb_valE, 0);
    chk({tag, ".valM"},  wb_valM, 0);
    chk({tag, ".dstE"},  32'(wb_dstE), 32'h0F);
    chk({tag, ".dstM"},  32'(wb_dstM), 32'h0F);
    chk({tag, ".stat"},  32'(wb_stat), 0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    mem_icode = v.icode; mem_valA = v.valA; mem_valP = v.valP; mem_valE = v.valE;
    mem_dstE = v.dstE; mem_dstM = v.dstM;
    dmem_ready = v.ready; dmem_rvalid = v.rvalid; dmem_rdata = v.rdata;
    #2;
    chk({tag, ".req"},   32'(dmem_req), 32'(v.x_req));
    chk({tag, ".stall"}, 32'(mem_stall), 32'(v.x_stall));
    if (v.x_req) begin
      chk({tag, ".we"},   32'(dmem_we), 32'(v.x_we));
      chk({tag, ".addr"}, dmem_addr, v.x_addr);
      if (v.x_we) chk({tag, ".wdata"}, dmem_wdata, v.x_wdata);
    end
    @(posedge clk);
    #1;
    chk({tag, ".wb_icode"}, 32'(wb_icode), 32'(v.x_icode));
    chk({tag, ".wb_valE"},  wb_valE, v.x_valE);
    chk({tag, ".wb_valM"},  wb_valM, v.x_valM);
    chk({tag, ".wb_dstE"},  32'(wb_dstE), 32'(v.x_dstE));
    chk({tag, ".wb_dstM"},  32'(wb_dstM), 32'(v.x_dstM));
    chk({tag, ".wb_stat"},  32'(wb_stat), 32'(v.x_stat));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = L;
    drive_nop();
    #1;
    chk_reset_vals(tag);
    @(negedge clk);
    rst = H;
  endtask

  initial begin
    rst = L;
    drive_nop();
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = H;

    // nop, write, read with 3-cycle latency, stalled push, call, pop, boundary read, stray rvalid, ret.
    vecs.push_back(mk (8'h01, 0, 0, 32'h5, 8'h03, 8'h0F, L, L, 0, L, L, 0, 0, L, 8'h01, 32'h5, 0, 8'h03, 8'h0F, 2'd0));
    vecs.push_back(mk (8'h04, 32'hDEADBEEF, 0, 32'h100, 8'h0F, 8'h0F, H, L, 0, H, H, 32'h100, 32'hDEADBEEF, L, 8'h04, 32'h100, 0, 8'h0F, 8'h0F, 2'd0));
    vecs.push_back(mkb(8'h05, 0, 0, 32'h40, 8'h0F, 8'h02, H, L, 0, H, L, 32'h40, 0, H, 2'd0));
    vecs.push_back(mkb(8'h05, 0, 0, 32'h40, 8'h0F, 8'h02, L, L, 0, L, L, 0, 0, H, 2'd0));
    vecs.push_back(mkb(8'h05, 0, 0, 32'h40, 8'h0F, 8'h02, L, L, 0, L, L, 0, 0, H, 2'd0));
    vecs.push_back(mk (8'h05, 0, 0, 32'h40, 8'h0F, 8'h02, H, H, 32'h12345678, L, L, 0, 0, L, 8'h05, 32'h40, 32'h12345678, 8'h0F, 8'h02, 2'd0));
    vecs.push_back(mkb(8'h0A, 32'hCAFE0001, 0, 32'h200, 8'h04, 8'h0F, L, L, 0, H, H, 32'h200, 32'hCAFE0001, H, 2'd0));
    vecs.push_back(mkb(8'h0A, 32'hCAFE0001, 0, 32'h200, 8'h04, 8'h0F, L, L, 0, H, H, 32'h200, 32'hCAFE0001, H, 2'd0));
    vecs.push_back(mk (8'h0A, 32'hCAFE0001, 0, 32'h200, 8'h04, 8'h0F, H, L, 0, H, H, 32'h200, 32'hCAFE0001, L, 8'h0A, 32'h200, 0, 8'h04, 8'h0F, 2'd0));
    vecs.push_back(mk (8'h08, 32'h99, 32'h33, 32'h300, 8'h04, 8'h0F, H, L, 0, H, H, 32'h300, 32'h33, L, 8'h08, 32'h300, 0, 8'h04, 8'h0F, 2'd0));
    vecs.push_back(mkb(8'h0B, 32'hFFC, 0, 32'h104, 8'h04, 8'h07, H, L, 0, H, L, 32'hFFC, 0, H, 2'd0));
    vecs.push_back(mk (8'h0B, 32'hFFC, 0, 32'h104, 8'h04, 8'h07, L, H, 32'hAABBCCDD, L, L, 0, 0, L, 8'h0B, 32'h104, 32'hAABBCCDD, 8'h04, 8'h07, 2'd0));
    vecs.push_back(mkb(8'h05, 0, 0, 32'hFFC, 8'h0F, 8'h02, H, L, 0, H, L, 32'hFFC, 0, H, 2'd0));
    vecs.push_back(mk (8'h05, 0, 0, 32'hFFC, 8'h0F, 8'h02, L, H, 32'h11, L, L, 0, 0, L, 8'h05, 32'hFFC, 32'h11, 8'h0F, 8'h02, 2'd0));
    vecs.push_back(mk (8'h01, 0, 0, 0, 8'h0F, 8'h0F, L, H, 32'hFFFFFFFF, L, L, 0, 0, L, 8'h01, 0, 0, 8'h0F, 8'h0F, 2'd0));
    vecs.push_back(mkb(8'h09, 32'h50, 0, 32'h54, 8'h04, 8'h0F, L, L, 0, H, L, 32'h50, 0, H, 2'd0));
    vecs.push_back(mkb(8'h09, 32'h50, 0, 32'h54, 8'h04, 8'h0F, H, L, 0, H, L, 32'h50, 0, H, 2'd0));
    vecs.push_back(mk (8'h09, 32'h50, 0, 32'h54, 8'h04, 8'h0F, L, H, 32'h77, L, L, 0, 0, L, 8'h09, 32'h54, 32'h77, 8'h04, 8'h0F, 2'd0));
    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Address fault one byte past the last legal word, then frozen.
    apply(mk (8'h05, 0, 0, 32'hFFD, 8'h0F, 8'h02, H, L, 0, L, L, 0, 0, L, 8'h05, 32'hFFD, 0, 8'h0F, 8'h0F, 2'd2), "adr");
    for (int i = 0; i < 2; i++)
      apply(mkb(8'h04, 32'h1, 0, 32'h100, 8'h0F, 8'h0F, H, L, 0, L, L, 0, 0, L, 2'd2), $sformatf("adr_frz%0d", i));
    pulse_reset("rst1");

    // Top-of-space address must not wrap into range.
    apply(mk (8'h05, 0, 0, 32'hFFFFFFFD, 8'h0F, 8'h02, H, L, 0, L, L, 0, 0, L, 8'h05, 32'hFFFFFFFD, 0, 8'h0F, 8'h0F, 2'd2), "adr_top");
    pulse_reset("rst2");

    // halt freezes; popl after it issues nothing.
    apply(mk (8'h00, 0, 0, 0, 8'h0F, 8'h0F, H, L, 0, L, L, 0, 0, L, 8'h00, 0, 0, 8'h0F, 8'h0F, 2'd1), "hlt");
    for (int i = 0; i < 2; i++)
      apply(mkb(8'h0B, 32'h10, 0, 32'h14, 8'h04, 8'h07, H, L, 0, L, L, 0, 0, L, 2'd1), $sformatf("hlt_frz%0d", i));
    pulse_reset("rst3");
    apply(mkb(8'h0B, 32'h10, 0, 32'h14, 8'h04, 8'h07, H, L, 0, H, L, 32'h10, 0, H, 2'd0), "pop_rd");
    apply(mk (8'h0B, 32'h10, 0, 32'h14, 8'h04, 8'h07, L, H, 32'h5A5A, L, L, 0, 0, L, 8'h0B, 32'h14, 32'h5A5A, 8'h04, 8'h07, 2'd0), "pop_rv");

    // Reset while a read is outstanding; the late rvalid must be ignored.
    apply(mkb(8'h05, 0, 0, 32'h80, 8'h0F, 8'h03, H, L, 0, H, L, 32'h80, 0, H, 2'd0), "rw_acc");
    apply(mkb(8'h05, 0, 0, 32'h80, 8'h0F, 8'h03, L, L, 0, L, L, 0, 0, H, 2'd0), "rw_wait");
    @(negedge clk);
    rst = L;
    #1;
    chk_reset_vals("rw_rst");
    @(negedge clk);
    rst = H;
    drive_nop();
    apply(mk (8'h01, 0, 0, 0, 8'h0F, 8'h0F, L, H, 32'hBAD0BAD0, L, L, 0, 0, L, 8'h01, 0, 0, 8'h0F, 8'h0F, 2'd0), "late_rv");
    apply(mkb(8'h05, 0, 0, 32'h84, 8'h0F, 8'h03, H, L, 0, H, L, 32'h84, 0, H, 2'd0), "post_rd");
    apply(mk (8'h05, 0, 0, 32'h84, 8'h0F, 8'h03, L, H, 32'h600D, L, L, 0, 0, L, 8'h05, 32'h84, 32'h600D, 8'h0F, 8'h03, 2'd0), "post_rv");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Y86 memory-access stage between the EX/MEM pipeline register and the writeback path. It decodes the latched `mem_icode`, issues read/write transactions to the data memory over a valid/ready handshake, and stalls upstream while a transaction is outstanding. It registers the result (valE, valM, destinations, status) toward writeback. On a memory fault or halt it freezes all further memory traffic until reset.

## Interface
Parameters:
- `DMEM_BYTES`, default 32'h0000_1000: size of data memory. Any access with addr > DMEM_BYTES-4 is an address fault.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_icode`  in  8: icode from EX/MEM.
- `mem_valA`, `mem_valP`, `mem_valE`  in  32 each: operands from EX/MEM.
- `mem_dstE`, `mem_dstM`  in  8 each: destination register IDs, 8'h0F = none.
- `dmem_req`  out  1: request valid.
- `dmem_we`  out  1: 1 = write.
- `dmem_addr`  out  32: byte address.
- `dmem_wdata`  out  32: write data.
- `dmem_ready`  in  1: request accepted this cycle when `dmem_req` is high.
- `dmem_rvalid`  in  1: read data valid, one pulse per accepted read.
- `dmem_rdata`  in  32: read data.
- `mem_stall`  out  1: hold EX/MEM and all earlier stages.
- `wb_icode`  out  8: registered icode toward writeback.
- `wb_valE`, `wb_valM`  out  32 each: registered values toward writeback.
- `wb_dstE`, `wb_dstM`  out  8 each: registered destinations toward writeback.
- `wb_stat`  out  2: 00 AOK, 01 HLT, 10 ADR.

## Operation
- Access decode:
  - rmmovl (4): write M[valE] = valA.
  - pushl (A): write M[valE] = valA.
  - call (8): write M[valE] = valP.
  - mrmovl (5): read M[valE].
  - popl (B): read M[valA].
  - ret (9): read M[valA].
  - halt (0): no access, stat HLT.
  - All other icodes: no access.
- FSM states:
  - IDLE: idle or presenting a new request.
  - REQ: request presented, not yet accepted.
  - RD_WAIT: read accepted, waiting for `dmem_rvalid`.
  - FROZEN: after a fault or halt.
- IDLE with a memory op and a legal address:
  - `dmem_req`=1.
  - If `dmem_ready`: a write completes; a read goes to RD_WAIT.
  - Otherwise go to REQ.
- REQ:
  - `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` stay stable until `dmem_ready`.
  - On accept, go as from IDLE.
- RD_WAIT: on `dmem_rvalid`, valM = `dmem_rdata`, complete, return to IDLE.
- Illegal address:
  - No request is issued.
  - Register stat ADR with `wb_dstE`/`wb_dstM` forced to 8'h0F.
  - Go to FROZEN.
- halt: register stat HLT, go to FROZEN.
- FROZEN:
  - `dmem_req`=0.
  - Output the bubble every cycle. Bubble = icode 1 (nop), dst 8'h0F, vals 0, stat held.
  - `mem_stall`=0.
  - Leave only via reset.
- `mem_stall`=1 whenever a memory op is present and has not completed this cycle. It is combinational from state, decode, `dmem_ready` and `dmem_rvalid`.
- `wb_*` registers:
  - On the completion edge they load icode/valE/dstE/dstM/stat, plus valM for reads (valM = 0 otherwise).
  - On stall edges they load the bubble.
- `dmem_rvalid` outside RD_WAIT is ignored.

## Timing
- Reset values, asserted asynchronously while `rst`=0:
  - State IDLE.
  - `wb_icode`=8'h01, `wb_valE`=`wb_valM`=0, `wb_dstE`=`wb_dstM`=8'h0F, `wb_stat`=00.
  - `dmem_req`=0, `mem_stall`=0.
- Non-memory op: 1-cycle latency, no stall.
- Write accepted on first presentation: 1 cycle, no stall. Each extra cycle of `dmem_ready`=0 adds 1 stall cycle.
- Read: accept at cycle t, `dmem_rvalid` at cycle t+k (k≥1).
  - `mem_stall` is high from t through t+k-1 and low in cycle t+k.
  - `wb_*` update on the edge ending cycle t+k.
- `dmem_ready` and `dmem_rvalid` high in the same cycle while in RD_WAIT: the rvalid belongs to the outstanding read. No new request is possible while stalled.
- Reset mid-transaction: abort to IDLE and drop `dmem_req`. A late `dmem_rvalid` after reset is ignored.
- Address boundary: DMEM_BYTES-4 is legal; DMEM_BYTES-3 faults. Compare in 32 bits with no wrap (addr ≥ 32'hFFFF_FFFD faults).

## Structure
- Shared package / defines:
  - icode constants (IHALT, INOP, IRMMOVL, IMRMOVL, ICALL, IRET, IPUSHL, IPOPL).
  - RNONE = 8'h0F.
  - Stat codes.
  - `BYTE`/`WORD` widths.
- Natural sub-module: `dmem_if`, which holds the request FSM (IDLE/REQ/RD_WAIT/FROZEN) and handshake. The top level does access decode and the `wb_*` register.

## Test plan
- rmmovl, valE=0x100, valA=0xDEADBEEF, `dmem_ready`=1 → one cycle with req, we=1, addr=0x100, wdata=0xDEADBEEF. `mem_stall` never high; `wb_stat`=00.
- mrmovl, valE=0x40, ready at once, rvalid 3 cycles later with 0x12345678 → `mem_stall` high 3 cycles, then `wb_valM`=0x12345678 and `wb_dstM`=mem_dstM.
- pushl with `dmem_ready` low for 2 cycles → addr/wdata/we stable across 3 req cycles, 2 stall cycles, bubbles (icode 1, dst 0F) on `wb_*` during the stall.
- mrmovl, valE=0xFFC with DMEM_BYTES=0x1000 → legal access. Same at valE=0xFFD → no `dmem_req`, `wb_stat`=10, dst 0F, and all subsequent rmmovl issue no req.
- halt followed by popl → `wb_stat`=01, no `dmem_req` ever. Reset then popl → normal read resumes.
- rst low during RD_WAIT, then rvalid pulse after release → outputs at reset values, rvalid ignored, `mem_stall`=0.
